// File: rtl/i2c_bit_sequencer.sv
// I2C bit-level sequencer: turns START/STOP/WRITE/READ commands into four-phase SCL/SDA open-drain drive.
// Latency: accept edge + 4*(div+1) cycles of phases; done pulses in the first IDLE cycle afterwards.
// Backpressure: cmd_ready is high only in IDLE (including the done cycle); cmd_valid is ignored while busy.
//
// Optional feature: CLOCK_STRETCH_EN -- when defined, the phase divider holds while SCL is
// released by us but a target keeps scl_in low.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   div             phase length minus one (clk cycles), latched at accept
//   cmd, cmd_valid  command (00 START, 01 STOP, 10 WRITE, 11 READ) and request
//   cmd_ready       high while idle
//   din             WRITE data bit, latched at accept
//   dout            bit captured by the last READ
//   done            one-cycle completion pulse
//   busy            command in progress
//   arb_lost        sticky arbitration-lost flag, cleared by the next accepted command
//   scl_oe, sda_oe  1 = pull line low, 0 = release
//   scl_in, sda_in  sampled line levels (already synchronised)
module i2c_bit_sequencer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             din,
  output logic             dout,
  output logic             done,
  output logic             busy,
  output logic             arb_lost,
  output logic             scl_oe,
  output logic             sda_oe,
  input  logic             scl_in,
  input  logic             sda_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STOP,
    S_WRITE,
    S_READ
  } state_t;

  state_t           r_state;
  logic [1:0]       r_phase;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic             r_din;
  logic             r_scl_oe;
  logic             r_sda_oe;
  logic             r_dout;
  logic             r_done;
  logic             r_arb;

  // Line levels for a given operation and phase, as {scl, sda}; 1 = released.
  function automatic logic [1:0] f_level(input state_t s, input logic [1:0] ph, input logic d);
    logic [1:0] lv;
    lv = 2'b11;
    case (s)
      S_START: begin
        case (ph)
          2'd0, 2'd1: lv = 2'b11;
          2'd2:       lv = 2'b10;
          default:    lv = 2'b00;
        endcase
      end
      S_STOP: begin
        case (ph)
          2'd0:       lv = 2'b00;
          2'd1, 2'd2: lv = 2'b10;
          default:    lv = 2'b11;
        endcase
      end
      S_WRITE: lv = {(ph == 2'd1) || (ph == 2'd2), d};
      S_READ:  lv = {(ph == 2'd1) || (ph == 2'd2), 1'b1};
      default: lv = 2'b11;
    endcase
    return lv;
  endfunction

  function automatic state_t f_cmd_state(input logic [1:0] c);
    state_t s;
    case (c)
      2'b00:   s = S_START;
      2'b01:   s = S_STOP;
      2'b10:   s = S_WRITE;
      default: s = S_READ;
    endcase
    return s;
  endfunction

  logic       w_stall;
  logic       w_last;
  logic       w_arb;
  logic [1:0] w_next_phase;
  logic [1:0] w_next_lvl;
  state_t     w_acc_state;
  logic [1:0] w_acc_lvl;

`ifdef CLOCK_STRETCH_EN
  // We released SCL this phase but a target is still holding it low.
  assign w_stall = !r_scl_oe && !scl_in;
`else
  logic w_unused_scl;
  assign w_unused_scl = scl_in;
  assign w_stall      = 1'b0;
`endif

  assign w_last       = (r_cnt == r_div);
  assign w_next_phase = r_phase + 2'd1;
  assign w_next_lvl   = f_level(r_state, w_next_phase, r_din);
  assign w_acc_state  = f_cmd_state(cmd);
  assign w_acc_lvl    = f_level(w_acc_state, 2'd0, din);

  // Arbitration check happens once, on the final cycle of the SCL-high data phase.
  assign w_arb = (r_state == S_WRITE) && r_din && !sda_in && (r_phase == 2'd2) && w_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_phase  <= 2'd0;
      r_cnt    <= '0;
      r_div    <= '0;
      r_din    <= 1'b0;
      r_scl_oe <= 1'b0;
      r_sda_oe <= 1'b0;
      r_dout   <= 1'b0;
      r_done   <= 1'b0;
      r_arb    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (cmd_valid) begin
          r_state  <= w_acc_state;
          r_phase  <= 2'd0;
          r_cnt    <= '0;
          r_div    <= div;
          r_din    <= din;
          r_arb    <= 1'b0;
          r_scl_oe <= !w_acc_lvl[1];
          r_sda_oe <= !w_acc_lvl[0];
        end
      end else if (!w_stall) begin
        if (r_state == S_READ && r_phase == 2'd2 && w_last) begin
          r_dout <= sda_in;
        end
        if (!w_last) begin
          r_cnt <= r_cnt + DIV_W'(1);
        end else if (w_arb) begin
          // Another master won: back off completely, no completion pulse.
          r_state  <= S_IDLE;
          r_phase  <= 2'd0;
          r_cnt    <= '0;
          r_arb    <= 1'b1;
          r_scl_oe <= 1'b0;
          r_sda_oe <= 1'b0;
        end else if (r_phase == 2'd3) begin
          // Lines keep their phase-3 levels while idle.
          r_state <= S_IDLE;
          r_phase <= 2'd0;
          r_cnt   <= '0;
          r_done  <= 1'b1;
        end else begin
          r_phase  <= w_next_phase;
          r_cnt    <= '0;
          r_scl_oe <= !w_next_lvl[1];
          r_sda_oe <= !w_next_lvl[0];
        end
      end
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign scl_oe    = r_scl_oe;
  assign sda_oe    = r_sda_oe;
  assign dout      = r_dout;
  assign done      = r_done;
  assign arb_lost  = r_arb;

endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// Bench for i2c_bit_sequencer: directed scenarios with literal expectations followed by
// randomized traffic, all cross-checked each cycle against a position-based model.
module tb_i2c_bit_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] div;
  logic [1:0] cmd;
  logic       cmd_valid, din, scl_in, sda_in;
  logic       cmd_ready, dout, done, busy, arb_lost, scl_oe, sda_oe;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  i2c_bit_sequencer #(.DIV_W(8)) dut (
    .clk(clk), .rst(rst), .div(div), .cmd(cmd), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .din(din), .dout(dout), .done(done), .busy(busy),
    .arb_lost(arb_lost), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .scl_in(scl_in), .sda_in(sda_in)
  );

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] outs();
    return {1'b0, scl_oe, sda_oe, done, busy, cmd_ready, dout, arb_lost};
  endfunction

  // ---------------- behavioural model ----------------
  // The command is viewed as a timeline of 4*(div+1) positions; phase = pos/(div+1).
  bit m_busy = 0, m_din = 0, m_scl_oe = 0, m_sda_oe = 0, m_dout = 0, m_done = 0, m_arb = 0;
  int m_cmd = 0, m_div = 0, m_pos = 0;

  // {scl, sda} released levels from the line table.
  function automatic bit [1:0] lvl(input int c, input int ph, input bit d);
    case (c)
      0: case (ph) 0, 1: return 2'b11; 2: return 2'b10; default: return 2'b00; endcase
      1: case (ph) 0: return 2'b00; 1, 2: return 2'b10; default: return 2'b11; endcase
      2: return {(ph == 1 || ph == 2), d};
      default: return {(ph == 1 || ph == 2), 1'b1};
    endcase
  endfunction

  task automatic model_step();
    int ph;
    bit last, stall;
    bit [1:0] l;
    if (!rst) begin
      m_busy = 0; m_pos = 0; m_scl_oe = 0; m_sda_oe = 0;
      m_dout = 0; m_done = 0; m_arb = 0;
      return;
    end
    m_done = 0;
    if (!m_busy) begin
      if (cmd_valid) begin
        m_busy = 1; m_cmd = int'(cmd); m_div = int'(div); m_din = din;
        m_pos = 0; m_arb = 0;
        l = lvl(m_cmd, 0, m_din);
        m_scl_oe = !l[1]; m_sda_oe = !l[0];
      end
    end else begin
      ph   = m_pos / (m_div + 1);
      last = (m_pos % (m_div + 1)) == m_div;
      l    = lvl(m_cmd, ph, m_din);
      stall = 0;
`ifdef CLOCK_STRETCH_EN
      stall = l[1] && !scl_in;
`endif
      if (!stall) begin
        if (last && ph == 2 && m_cmd == 3) m_dout = sda_in;
        if (last && ph == 2 && m_cmd == 2 && m_din && !sda_in) begin
          m_arb = 1; m_busy = 0; m_scl_oe = 0; m_sda_oe = 0;
        end else if (last && ph == 3) begin
          m_busy = 0; m_done = 1;
        end else begin
          m_pos++;
          l = lvl(m_cmd, m_pos / (m_div + 1), m_din);
          m_scl_oe = !l[1]; m_sda_oe = !l[0];
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    model_step();
  end

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_on)
      check("cycle", outs(),
            {1'b0, m_scl_oe, m_sda_oe, m_done, m_busy, !m_busy, m_dout, m_arb});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command and returns 1 time unit after its accept edge (position 0).
  // div/din are scrambled afterwards: the latched copies must be the ones used.
  task automatic issue(input int c, input int d, input bit di);
    cmd = 2'(c); div = 8'(d); din = di; cmd_valid = 1'b1;
    check("issue_ready", {7'b0, cmd_ready}, 8'd1);
    step();
    cmd_valid = 1'b0;
    div = 8'($urandom_range(0, 255));
    din = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int j);
    j = 0;
    while (!done && j < 80) begin
      step();
      j++;
    end
  endtask

  bit [1:0] exp_start [4];
  int j;
  int seen;

  initial begin
    rst = 1'b0; cmd = 2'b00; div = 8'd0; cmd_valid = 1'b0; din = 1'b0;
    scl_in = 1'b1; sda_in = 1'b1;
    exp_start = '{2'b00, 2'b00, 2'b01, 2'b11};

    // Reset values, while held and after release.
    repeat (3) step();
    check("reset_hold", outs(), 8'b0000_0100);
    rst = 1'b1;
    step();
    check("reset_release", outs(), 8'b0000_0100);
    chk_on = 1'b1;

    // START, div=3: 4 cycles per phase; done in the 17th cycle counting the accept cycle.
    issue(0, 3, 1'b0);
    for (int k = 0; k <= 16; k++) begin
      if (k % 4 == 2) check("start_lines", {6'b0, scl_oe, sda_oe}, {6'b0, exp_start[k / 4]});
      if (k < 16) step();
    end
    check("start_done", {6'b0, done, busy}, 8'b10);
    step();
    check("done_one_cycle", {5'b0, done, scl_oe, sda_oe}, 8'b011);

    // WRITE din=0 then READ back-to-back, div=0, READ sees sda_in=1.
    issue(2, 0, 1'b0);
    div = 8'd0; cmd = 2'b11; cmd_valid = 1'b1; sda_in = 1'b1;
    check("write0_ph0", {6'b0, scl_oe, sda_oe}, 8'b11);
    step();
    check("write0_ph1", {6'b0, scl_oe, sda_oe}, 8'b01);
    repeat (3) step();
    check("b2b_done_ready", {6'b0, done, cmd_ready}, 8'b11);
    step();
    cmd_valid = 1'b0;
    check("b2b_accept", {7'b0, busy}, 8'd1);
    wait_done(j);
    check("read_latency", 8'(j), 8'd4);
    check("read_dout", {7'b0, dout}, 8'd1);
    step();

    // WRITE din=1, div=1, sda pulled low in phase 2: arbitration lost.
    issue(2, 1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 3) sda_in = 1'b0;
    end
    check("arb_lost", {3'b0, scl_oe, sda_oe, done, busy, arb_lost}, 8'b00001);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) seen++;
      step();
    end
    check("arb_no_done", 8'(seen), 8'd0);
    sda_in = 1'b1;
    issue(0, 0, 1'b0);
    check("arb_clear", {7'b0, arb_lost}, 8'd0);
    wait_done(j);
    step();

    // READ, div=1, scl_in held low for 10 cycles during phase 1.
    issue(3, 1, 1'b0);
    j = 0;
    while (!done && j < 80) begin
      step();
      j++;
      if (j == 2)  scl_in = 1'b0;
      if (j == 12) scl_in = 1'b1;
    end
`ifdef CLOCK_STRETCH_EN
    check("stretch_latency", 8'(j), 8'd18);
`else
    check("stretch_latency", 8'(j), 8'd8);
`endif
    step();

    // Reset in STOP phase 2 aborts at once with released lines and no done.
    issue(1, 2, 1'b0);
    repeat (6) step();
    check("stop_ph2", {6'b0, scl_oe, sda_oe}, 8'b01);
    step();
    rst = 1'b0;
    #1;
    check("rst_abort", {3'b0, scl_oe, sda_oe, done, busy, cmd_ready}, 8'b00001);
    step();
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (done) seen++;
    end
    check("rst_no_done", 8'(seen), 8'd0);

    // Randomized traffic, including mid-command input changes and rare resets.
    for (int k = 0; k < 4000; k++) begin
      step();
      rst       = ($urandom_range(0, 399) != 0);
      cmd       = 2'($urandom_range(0, 3));
      div       = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 3));
      cmd_valid = 1'($urandom_range(0, 1));
      din       = 1'($urandom_range(0, 1));
      sda_in    = ($urandom_range(0, 3) != 0);
      scl_in    = ($urandom_range(0, 3) != 0);
    end
    rst = 1'b1; cmd_valid = 1'b0;
    repeat (60) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
